// File: rtl/prio_encoder_pkg.sv
// ---------------------------------------------------------------------------
// prio_encoder_pkg
// Elaboration-time helpers for the fixed-priority encoder tree.
//   tree_leaves(n)       : number of leaves of the balanced tree holding n
//                          request lines (n rounded up to a power of two).
//   node_height(node,ew) : height above the leaves of a heap-numbered tree
//                          node (root = 1, children of k are 2k and 2k+1).
// ---------------------------------------------------------------------------
package prio_encoder_pkg;

  function automatic int unsigned tree_leaves(input int unsigned n);
    return 32'd1 << $clog2(n);
  endfunction

  // floor(log2(node)) is the depth of the node; height = ew - depth.
  function automatic int unsigned node_height(input int unsigned node,
                                              input int unsigned ew);
    return ew + 32'd1 - $clog2(node + 32'd1);
  endfunction

endpackage

// File: rtl/prio_encoder.sv
// ---------------------------------------------------------------------------
// prio_encoder
// Fixed-priority encoder: reports the index of the lowest set request line
// (bit 0 has highest priority) and whether any line is set. Built as a
// log-depth binary tree of (valid, index) pairs; the lower half always wins.
// Suitable as a free-slot / ready-entry picker (valid_o may be left open).
//
// Parameters
//   N        number of request lines (>= 2, any value)
//   OUT_REG  0: outputs are combinational in lines_i
//            1: outputs registered, one cycle latency, async reset to zero
// Ports
//   clk_i    in   1          clock, rising edge (only used when OUT_REG=1)
//   rst_ni   in   1          async active-low reset (only used when OUT_REG=1)
//   lines_i  in   N          request lines
//   enc_o    out  clog2(N)   index of the winning line, 0 when none set
//   valid_o  out  1          OR of all request lines
// ---------------------------------------------------------------------------
module prio_encoder
  import prio_encoder_pkg::*;
#(
  parameter int unsigned N       = 4,
  parameter bit          OUT_REG = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [N-1:0]         lines_i,
  output logic [$clog2(N)-1:0] enc_o,
  output logic                 valid_o
);

  localparam int unsigned EW = $clog2(N);
  localparam int unsigned P  = tree_leaves(N);

  // Heap-numbered tree: node 1 is the root, leaves occupy P..2P-1.
  logic [2*P-1:1]         node_vld;
  logic [2*P-1:1][EW-1:0] node_idx;

  logic [EW-1:0] enc_d;
  logic          valid_d;

  // Leaves beyond N are padding and can never win.
  for (genvar i = 0; i < P; i++) begin : g_leaf
    if (i < N) begin : g_real
      assign node_vld[P+i] = lines_i[i];
    end else begin : g_pad
      assign node_vld[P+i] = 1'b0;
    end
    assign node_idx[P+i] = '0;
  end

  // Each node merges its two children. The upper child's index gains the
  // bit that distinguishes the two halves at this height.
  for (genvar k = 1; k < P; k++) begin : g_node
    localparam int unsigned   H      = node_height(k, EW);
    localparam logic [EW-1:0] HI_BIT = EW'(1) << (H - 1);

    assign node_vld[k] = node_vld[2*k] | node_vld[2*k+1];
    assign node_idx[k] = node_vld[2*k] ? node_idx[2*k]
                                       : (node_idx[2*k+1] | HI_BIT);
  end

  // With no line set the tree index is meaningless, so force it to zero.
  always_comb begin
    valid_d = node_vld[1];
    enc_d   = '0;
    if (node_vld[1]) begin
      enc_d = node_idx[1];
    end
  end

  if (OUT_REG) begin : g_reg
    logic [EW-1:0] enc_q;
    logic          valid_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        enc_q   <= '0;
        valid_q <= 1'b0;
      end else begin
        enc_q   <= enc_d;
        valid_q <= valid_d;
      end
    end

    assign enc_o   = enc_q;
    assign valid_o = valid_q;
  end else begin : g_comb
    // Clock and reset are intentionally ignored in the combinational build.
    logic unused_clk_rst;
    assign unused_clk_rst = clk_i ^ rst_ni;

    assign enc_o   = enc_d;
    assign valid_o = valid_d;
  end

endmodule

// File: tb/tb_prio_encoder.sv
// ---------------------------------------------------------------------------
// tb_prio_encoder
// Directed checks of prio_encoder in four configurations: N=4 combinational,
// N=5 combinational, N=4 registered and N=64 combinational.
// ---------------------------------------------------------------------------
module tb_prio_encoder;

  logic clk;
  logic rst_n;

  logic [3:0]  lines4c;
  logic [1:0]  enc4c;
  logic        valid4c;

  logic [4:0]  lines5;
  logic [2:0]  enc5;
  logic        valid5;

  logic [3:0]  lines4r;
  logic [1:0]  enc4r;
  logic        valid4r;

  logic [63:0] lines64;
  logic [5:0]  enc64;
  logic        valid64;

  int checks;
  int fails;

  prio_encoder #(.N(4), .OUT_REG(1'b0)) u_n4c (
    .clk_i(clk), .rst_ni(rst_n), .lines_i(lines4c), .enc_o(enc4c), .valid_o(valid4c)
  );

  prio_encoder #(.N(5), .OUT_REG(1'b0)) u_n5 (
    .clk_i(clk), .rst_ni(rst_n), .lines_i(lines5), .enc_o(enc5), .valid_o(valid5)
  );

  prio_encoder #(.N(4), .OUT_REG(1'b1)) u_n4r (
    .clk_i(clk), .rst_ni(rst_n), .lines_i(lines4r), .enc_o(enc4r), .valid_o(valid4r)
  );

  prio_encoder #(.N(64), .OUT_REG(1'b0)) u_n64 (
    .clk_i(clk), .rst_ni(rst_n), .lines_i(lines64), .enc_o(enc64), .valid_o(valid64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: index of the lowest set bit, 0 when nothing is set.
  function automatic int lowest_set(input logic [63:0] v);
    for (int i = 0; i < 64; i++) begin
      if (v[i]) return i;
    end
    return 0;
  endfunction

  task automatic test_reset();
    rst_n   = 1'b0;
    lines4r = 4'b1111;
    lines4c = 4'b0100;
    #1;
    checks++;
    if (enc4r !== 2'd0 || valid4r !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_reg: got enc=%0d valid=%0b, want enc=0 valid=0", enc4r, valid4r);
    end
    // Combinational build must ignore reset.
    checks++;
    if (enc4c !== 2'd2 || valid4c !== 1'b1) begin
      fails++;
      $display("[TB] FAIL reset_comb: got enc=%0d valid=%0b, want enc=2 valid=1", enc4c, valid4c);
    end
  endtask

  task automatic test_comb_n4();
    logic [3:0] vec   [6] = '{4'b0000, 4'b1000, 4'b1010, 4'b1111, 4'b0100, 4'b0110};
    logic [1:0] exp_e [6] = '{2'd0,    2'd3,    2'd1,    2'd0,    2'd2,    2'd1};
    logic       exp_v [6] = '{1'b0,    1'b1,    1'b1,    1'b1,    1'b1,    1'b1};
    for (int i = 0; i < 6; i++) begin
      lines4c = vec[i];
      #1;
      checks++;
      if (enc4c !== exp_e[i] || valid4c !== exp_v[i]) begin
        fails++;
        $display("[TB] FAIL comb_n4 lines=%b: got enc=%0d valid=%0b, want enc=%0d valid=%0b",
                 vec[i], enc4c, valid4c, exp_e[i], exp_v[i]);
      end
    end
  endtask

  task automatic test_exhaustive_n5();
    int e;
    for (int v = 0; v < 32; v++) begin
      lines5 = 5'(v);
      #1;
      e = lowest_set(64'(v));
      checks++;
      if (enc5 !== 3'(e) || valid5 !== (v != 0)) begin
        fails++;
        $display("[TB] FAIL exh_n5 lines=%b: got enc=%0d valid=%0b, want enc=%0d valid=%0b",
                 lines5, enc5, valid5, e, (v != 0));
      end
    end
    lines5 = 5'b10000;
    #1;
    checks++;
    if (enc5 !== 3'd4 || valid5 !== 1'b1) begin
      fails++;
      $display("[TB] FAIL top_n5: got enc=%0d valid=%0b, want enc=4 valid=1", enc5, valid5);
    end
  endtask

  task automatic test_registered();
    @(negedge clk);
    rst_n   = 1'b1;
    lines4r = 4'b0110;
    #1;
    checks++;
    if (enc4r !== 2'd0 || valid4r !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reg_before_edge: got enc=%0d valid=%0b, want enc=0 valid=0", enc4r, valid4r);
    end
    @(posedge clk);
    #1;
    checks++;
    if (enc4r !== 2'd1 || valid4r !== 1'b1) begin
      fails++;
      $display("[TB] FAIL reg_after_edge: got enc=%0d valid=%0b, want enc=1 valid=1", enc4r, valid4r);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    lines4r = 4'b0100;
    @(posedge clk);
    #1;
    checks++;
    if (enc4r !== 2'd2 || valid4r !== 1'b1) begin
      fails++;
      $display("[TB] FAIL mid_load: got enc=%0d valid=%0b, want enc=2 valid=1", enc4r, valid4r);
    end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (enc4r !== 2'd0 || valid4r !== 1'b0) begin
      fails++;
      $display("[TB] FAIL mid_reset: got enc=%0d valid=%0b, want enc=0 valid=0", enc4r, valid4r);
    end
    rst_n   = 1'b1;
    lines4r = 4'b1000;
    #1;
    checks++;
    if (enc4r !== 2'd0 || valid4r !== 1'b0) begin
      fails++;
      $display("[TB] FAIL mid_release_hold: got enc=%0d valid=%0b, want enc=0 valid=0", enc4r, valid4r);
    end
    @(posedge clk);
    #1;
    checks++;
    if (enc4r !== 2'd3 || valid4r !== 1'b1) begin
      fails++;
      $display("[TB] FAIL mid_reload: got enc=%0d valid=%0b, want enc=3 valid=1", enc4r, valid4r);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] vec   [4] = '{4'b0001, 4'b0000, 4'b1100, 4'b1010};
    logic [1:0] exp_e [4] = '{2'd0,    2'd0,    2'd2,    2'd1};
    logic       exp_v [4] = '{1'b1,    1'b0,    1'b1,    1'b1};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      lines4r = vec[i];
      @(posedge clk);
      #1;
      checks++;
      if (enc4r !== exp_e[i] || valid4r !== exp_v[i]) begin
        fails++;
        $display("[TB] FAIL b2b[%0d] lines=%b: got enc=%0d valid=%0b, want enc=%0d valid=%0b",
                 i, vec[i], enc4r, valid4r, exp_e[i], exp_v[i]);
      end
    end
  endtask

  task automatic test_n64();
    logic [63:0] v;
    int          e;
    for (int i = 0; i < 64; i++) begin
      lines64 = 64'd1 << i;
      #1;
      checks++;
      if (enc64 !== 6'(i) || valid64 !== 1'b1) begin
        fails++;
        $display("[TB] FAIL onehot_n64 bit=%0d: got enc=%0d valid=%0b, want enc=%0d valid=1",
                 i, enc64, valid64, i);
      end
    end
    for (int k = 0; k < 10000; k++) begin
      v = {$urandom, $urandom};
      // Thin out and shift some vectors so high indices and zero get exercised.
      if (k % 3 == 1) v = v & {$urandom, $urandom} & {$urandom, $urandom};
      if (k % 4 == 2) v = v << $urandom_range(63, 0);
      if (k % 500 == 0) v = '0;
      lines64 = v;
      #1;
      e = lowest_set(v);
      checks++;
      if (enc64 !== 6'(e) || valid64 !== (|v)) begin
        fails++;
        $display("[TB] FAIL rand_n64 lines=%h: got enc=%0d valid=%0b, want enc=%0d valid=%0b",
                 v, enc64, valid64, e, (|v));
      end
    end
  endtask

  initial begin
    checks  = 0;
    fails   = 0;
    lines4c = '0;
    lines5  = '0;
    lines4r = '0;
    lines64 = '0;
    test_reset();
    test_comb_n4();
    test_exhaustive_n5();
    test_registered();
    test_reset_mid();
    test_back_to_back();
    test_n64();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
